// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops WID-bit words from a FIFO and sends them byte 0 first, LSB first, as UART frames.
// Ports: clk, rst_n (async active-low), softreset (sync abort), enable (allow pop),
//   baud_div (bit time = baud_div+1 clk, latched at pop), empty/dataout (FIFO head),
//   readout (pop strobe, combinational), txd (registered serial line, idle high),
//   busy (word in flight), words_sent (completed words, wraps).
// Build option: FIFO_UART_TX_PARITY_EN adds an even-parity bit after the 8 data bits.
module fifo_uart_tx #(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           softreset,
  input  logic           enable,
  input  logic [15:0]    baud_div,
  input  logic           empty,
  input  logic [WID-1:0] dataout,
  output logic           readout,
  output logic           txd,
  output logic           busy,
  output logic [15:0]    words_sent
);
  localparam int NB = WID / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [WID-1:0] sh;
  logic [7:0] cur;
  logic [15:0] div, cnt;
  logic [IW-1:0] idx;
  logic [2:0] bitn;
  logic txd_n, tick, last;
  // The word is shifted down a byte after each stop bit, so the byte on the line is always sh[7:0].
  assign cur = sh[7:0];
  assign tick = cnt == 16'd0;
  assign last = idx == LAST;
  assign readout = rst_n && state == IDLE && enable && !empty && !softreset;
  assign busy = state != IDLE;
  // txd_n is the line level for the cycle after the edge, so txd stays a plain register.
  always_comb begin
    state_n = state;
    txd_n = txd;
    case (state)
      IDLE: if (readout) begin state_n = START; txd_n = 1'b0; end
      START: if (tick) begin state_n = DATA; txd_n = cur[0]; end
      DATA: if (tick) begin
        if (bitn == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_n = PAR;
          txd_n = ^cur;
`else
          state_n = STOP;
          txd_n = 1'b1;
`endif
        end else txd_n = cur[bitn + 3'd1];
      end
      PAR: if (tick) begin state_n = STOP; txd_n = 1'b1; end
      STOP: if (tick) begin state_n = last ? IDLE : START; txd_n = last; end
      default: begin state_n = IDLE; txd_n = 1'b1; end
    endcase
    if (softreset) begin
      state_n = IDLE;
      txd_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      txd <= 1'b1;
      div <= '0;
      cnt <= '0;
      idx <= '0;
      bitn <= '0;
      words_sent <= '0;
    end else begin
      state <= state_n;
      txd <= txd_n;
      if (softreset) begin
        cnt <= '0;
        idx <= '0;
        bitn <= '0;
        words_sent <= '0;
      end else if (readout) begin
        div <= baud_div;
        cnt <= baud_div;
        idx <= '0;
        bitn <= '0;
      end else if (busy) begin
        cnt <= tick ? div : cnt - 16'd1;
        if (tick && state == DATA) bitn <= bitn + 3'd1;
        if (tick && state == STOP) begin
          idx <= last ? '0 : idx + IW'(1);
          if (last) words_sent <= words_sent + 16'd1;
        end
      end
    end
  end
  // Data payload carries no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (readout) sh <= dataout;
    else if (state == STOP && tick) sh <= sh >> 8;
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a frame-queue model and literal spot checks.
module tb_fifo_uart_tx;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif
  logic clk = 0, rst_n = 0, softreset = 0, enable = 0, empty = 1;
  logic [15:0] baud_div = 0;
  logic [31:0] dataout = 0;
  logic readout, txd, busy;
  logic [15:0] words_sent;
  int total = 0, bad = 0, nw = 0;
  logic [31:0] fifo[$];
  bit q[$];
  logic m_txd = 1;
  logic [15:0] m_ws = 0;

  fifo_uart_tx #(.WID(32)) dut (
    .clk(clk), .rst_n(rst_n), .softreset(softreset), .enable(enable), .baud_div(baud_div),
    .empty(empty), .dataout(dataout), .readout(readout), .txd(txd), .busy(busy),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_rd();
    return rst_n && q.size() == 0 && enable && fifo.size() != 0 && !softreset;
  endfunction

  task automatic put_bit(input bit v, input int d);
    repeat (d + 1) q.push_back(v);
  endtask

  // Whole line waveform of one word, one entry per clock cycle.
  task automatic build(input logic [31:0] w, input int d);
    logic [7:0] by;
    for (int b = 0; b < 4; b++) begin
      by = 8'(w >> (8 * b));
      put_bit(0, d);
      for (int k = 0; k < 8; k++) put_bit(by[k], d);
`ifdef FIFO_UART_TX_PARITY_EN
      put_bit(^by, d);
`endif
      put_bit(1, d);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || softreset) begin
      q.delete();
      m_txd = 1;
      m_ws = 0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_ws++;
        m_txd = 1;
      end else m_txd = q[0];
    end else if (exp_rd()) begin
      build(fifo.pop_front(), int'(baud_div));
      m_txd = q[0];
    end
  end

  always @(posedge clk) begin
    #2;
    empty = fifo.size() == 0;
    dataout = fifo.size() != 0 ? fifo[0] : 32'h0;
  end

  always @(negedge clk) begin
    chk("readout", readout, exp_rd());
    chk("txd", txd, m_txd);
    chk("busy", busy, q.size() != 0);
    chk("words_sent", words_sent, m_ws);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    empty = 0;
    dataout = fifo[0];
  endtask

  task automatic wait_rd();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (readout) break;
    end
    if (i == 300) chk("rd_timeout", 0, 1);
  endtask

  // Records txd from the cycle after the pop until busy drops, then decodes it.
  task automatic watch_word(input int d, input int chg, output int n, output logic [31:0] w,
                            output logic [3:0] p, output logic [4:0] head);
    logic tx[2048];
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == chg) baud_div = 16'd7;
      if (!busy) break;
      tx[n] = txd;
      n++;
    end
    if (n == 2000) chk("busy_timeout", 0, 1);
    w = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) w[8 * b + k] = tx[(b * FR + 1 + k) * (d + 1)];
      p[b] = tx[(b * FR + 9) * (d + 1)];
    end
    head = {tx[4], tx[3], tx[2], tx[1], tx[0]};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, rd_cnt;
    logic [31:0] w;
    logic [3:0] p;
    logic [4:0] head;
    logic all_hi;
    repeat (3) step();
    rst_n = 1;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ws", words_sent, 0);
    // enable low holds off the pop
    step();
    push(32'hA5C30F01);
    rd_cnt = 0;
    all_hi = 1;
    repeat (50) begin
      @(negedge clk);
      rd_cnt += int'(readout);
      all_hi &= txd;
    end
    chk("hold_readout", rd_cnt, 0);
    chk("hold_txd", all_hi, 1);
    step();
    enable = 1;
    @(negedge clk);
    chk("en_readout", readout, 1);
    watch_word(0, -1, n, w, p, head);
    nw++;
    chk("w1_busy", n, FR * 4);
    chk("w1_word", w, 32'hA5C30F01);
    chk("w1_ws", words_sent, nw);
    // single word, 4 cycles per bit
    step();
    baud_div = 3;
    push(32'h44332211);
    wait_rd();
    watch_word(3, -1, n, w, p, head);
    nw++;
    chk("w2_busy", n, FR * 16);
    chk("w2_word", w, 32'h44332211);
    chk("w2_head", head, 5'b10000);
    chk("w2_ws", words_sent, nw);
`ifdef FIFO_UART_TX_PARITY_EN
    step();
    baud_div = 0;
    push(32'h00000007);
    wait_rd();
    watch_word(0, -1, n, w, p, head);
    nw++;
    chk("par_busy", n, 44);
    chk("par_word", w, 32'h7);
    chk("par_bits", p, 4'b0001);
`endif
    // back-to-back words
    enable = 0;
    step();
    baud_div = 0;
    push(32'h01020304);
    push(32'hDEADBEEF);
    step();
    enable = 1;
    wait_rd();
    watch_word(0, -1, n, w, p, head);
    nw++;
    chk("b2b_w1", w, 32'h01020304);
    chk("b2b_gap_readout", readout, 1);
    chk("b2b_gap_txd", txd, 1);
    watch_word(0, -1, n, w, p, head);
    nw++;
    chk("b2b_w2", w, 32'hDEADBEEF);
    chk("b2b_ws", words_sent, nw);
    // softreset in DATA of byte 1
    step();
    baud_div = 3;
    push(32'hCAFEF00D);
    push(32'h00FF00FF);
    wait_rd();
    repeat (50) step();
    softreset = 1;
    @(negedge clk);
    chk("sr_busy_before", busy, 1);
    step();
    @(negedge clk);
    chk("sr_txd", txd, 1);
    chk("sr_busy", busy, 0);
    chk("sr_ws", words_sent, 0);
    chk("sr_readout", readout, 0);
    nw = 0;
    step();
    softreset = 0;
    @(negedge clk);
    chk("sr_repop", readout, 1);
    watch_word(3, -1, n, w, p, head);
    nw++;
    chk("sr_word", w, 32'h00FF00FF);
    chk("sr_ws_after", words_sent, nw);
    // async reset mid stop bit, then divisor change mid word
    step();
    push(32'h12345678);
    push(32'h000000C3);
    wait_rd();
    repeat (38) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("ar_txd", txd, 1);
    chk("ar_busy", busy, 0);
    chk("ar_readout", readout, 0);
    chk("ar_ws", words_sent, 0);
    nw = 0;
    repeat (2) step();
    rst_n = 1;
    wait_rd();
    watch_word(3, 10, n, w, p, head);
    nw++;
    chk("ar_busy_len", n, FR * 16);
    chk("ar_word", w, 32'h000000C3);
    chk("ar_head", head, 5'b10000);
    chk("ar_ws_after", words_sent, nw);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
